// File: rtl/exec_stage_if.sv
// exec_stage_if: E-stage control/data in, M-stage pipeline register out
interface exec_stage_if #(parameter int XLEN = 32);
  logic            regWrte, memWrte, jmpe, branche, aluSrce, jalre;
  logic [1:0]      resltSrce, ujMuxe;
  logic [3:0]      aluCtrle;
  logic [2:0]      funct3e;
  logic [XLEN-1:0] rd1e, rd2e, pce, pc4e, immexte;
  logic [4:0]      rde;
  logic [1:0]      fwdAe, fwdBe;
  logic [XLEN-1:0] resltw;
  logic            pcSrce;
  logic [XLEN-1:0] pcTargete;
  logic            stalle;
  logic            regWrtm, memWrtm;
  logic [1:0]      resltSrcm;
  logic [XLEN-1:0] aluRsltm, wrtDatam, pc4m;
  logic [4:0]      rdm;
  modport master (
    output regWrte, memWrte, jmpe, branche, aluSrce, jalre, resltSrce, ujMuxe,
           aluCtrle, funct3e, rd1e, rd2e, pce, pc4e, immexte, rde, fwdAe, fwdBe, resltw,
    input  pcSrce, pcTargete, stalle, regWrtm, memWrtm, resltSrcm, aluRsltm, wrtDatam, pc4m, rdm
  );
  modport slave (
    input  regWrte, memWrte, jmpe, branche, aluSrce, jalre, resltSrce, ujMuxe,
           aluCtrle, funct3e, rd1e, rd2e, pce, pc4e, immexte, rde, fwdAe, fwdBe, resltw,
    output pcSrce, pcTargete, stalle, regWrtm, memWrtm, resltSrcm, aluRsltm, wrtDatam, pc4m, rdm
  );
endinterface

// File: rtl/exec_stage.sv
// exec_stage: RISC-V execute stage with forwarding, ALU, branch resolve, iterative mul/div and EX/MEM register
module exec_stage #(
  parameter int XLEN      = 32,
  parameter int MD_CYCLES = 32
) (
  input logic        clk,
  input logic        rst,
  exec_stage_if.slave e
);
  localparam int CW = $clog2(MD_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_op;
  logic [XLEN-1:0] r_acc, r_x, r_y;
  logic            r_reg_wrt, r_mem_wrt;
  logic [1:0]      r_reslt_src;
  logic [XLEN-1:0] r_alu_rslt, r_wrt_data, r_pc4;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] w_fwd_a, w_fwd_b, w_src_a, w_src_b, w_alu, w_md_res, w_alu_out, w_jalr_sum;
  logic [4:0]      w_shamt;
  logic [XLEN:0]   w_rem_sh, w_diff;
  logic            w_div_ge, w_is_md, w_stall, w_eq, w_lt, w_ltu, w_cond;
  // operand forwarding and ALU source selection; select 11 falls back to the register value
  always_comb begin
    w_fwd_a = e.fwdAe == 2'b01 ? e.resltw : e.fwdAe == 2'b10 ? r_alu_rslt : e.rd1e;
    w_fwd_b = e.fwdBe == 2'b01 ? e.resltw : e.fwdBe == 2'b10 ? r_alu_rslt : e.rd2e;
    w_src_a = e.ujMuxe == 2'b01 ? e.pce : e.ujMuxe == 2'b10 ? '0 : w_fwd_a;
    w_src_b = e.aluSrce ? e.immexte : w_fwd_b;
    w_shamt = w_src_b[4:0];
  end
  // single-cycle ALU; mul/div codes yield 0 here because their result comes from the iterative unit
  always_comb begin
    w_alu = '0;
    case (e.aluCtrle)
      4'b0000: w_alu = w_src_a + w_src_b;
      4'b0001: w_alu = w_src_a - w_src_b;
      4'b0010: w_alu = w_src_a & w_src_b;
      4'b0011: w_alu = w_src_a | w_src_b;
      4'b0100: w_alu = w_src_a ^ w_src_b;
      4'b0101: w_alu = XLEN'($signed(w_src_a) < $signed(w_src_b));
      4'b0110: w_alu = XLEN'(w_src_a < w_src_b);
      4'b0111: w_alu = w_src_a << w_shamt;
      4'b1000: w_alu = w_src_a >> w_shamt;
      4'b1001: w_alu = $signed(w_src_a) >>> w_shamt;
      4'b1010: w_alu = w_src_b;
      default: w_alu = '0;
    endcase
  end
  // branch condition on forwarded rs1/rs2; odd funct3 inverts the base test, 010/011 never taken
  always_comb begin
    w_eq       = w_fwd_a == w_fwd_b;
    w_lt       = $signed(w_fwd_a) < $signed(w_fwd_b);
    w_ltu      = w_fwd_a < w_fwd_b;
    w_cond     = e.funct3e[2] ? ((e.funct3e[1] ? w_ltu : w_lt) ^ e.funct3e[0])
                              : (!e.funct3e[1] & (w_eq ^ e.funct3e[0]));
    w_jalr_sum = w_fwd_a + e.immexte;
  end
  // stall is raised combinationally from the cycle an M op is seen until the iterations finish
  always_comb begin
    w_is_md   = e.aluCtrle inside {4'b1100, 4'b1110, 4'b1111};
    w_stall   = !rst && ((r_state == IDLE && w_is_md) || r_state == BUSY);
    w_md_res  = r_op == 4'b1110 ? r_x : r_acc;
    w_alu_out = r_state == DONE ? w_md_res : w_alu;
    w_rem_sh  = {r_acc, r_x[XLEN-1]};
    w_diff    = w_rem_sh - {1'b0, r_y};
    w_div_ge  = !w_diff[XLEN];
  end
  // mul/div FSM next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_is_md ? BUSY : IDLE;
      BUSY:    w_next = r_cnt == CW'(MD_CYCLES - 1) ? DONE : BUSY;
      default: w_next = IDLE;
    endcase
  end
  // mul/div datapath: shift-add multiply (acc += x, x<<1, y>>1) or restoring divide (acc=rem, x=quotient, y=divisor)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_acc   <= '0;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_is_md) begin
        r_cnt <= '0;
        r_op  <= e.aluCtrle;
        r_acc <= '0;
        r_x   <= w_src_a;
        r_y   <= w_src_b;
      end else if (r_state == BUSY) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_op == 4'b1100) begin
          r_acc <= r_acc + (r_y[0] ? r_x : '0);
          r_x   <= r_x << 1;
          r_y   <= r_y >> 1;
        end else begin
          r_acc <= w_div_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
          r_x   <= {r_x[XLEN-2:0], w_div_ge};
        end
      end
    end
  end
  // EX/MEM pipeline register; a bubble is inserted while the stage is stalled
  always_ff @(posedge clk) begin
    if (rst || w_stall) begin
      r_reg_wrt   <= 1'b0;
      r_mem_wrt   <= 1'b0;
      r_reslt_src <= '0;
      r_alu_rslt  <= '0;
      r_wrt_data  <= '0;
      r_pc4       <= '0;
      r_rd        <= '0;
    end else begin
      r_reg_wrt   <= e.regWrte;
      r_mem_wrt   <= e.memWrte;
      r_reslt_src <= e.resltSrce;
      r_alu_rslt  <= w_alu_out;
      r_wrt_data  <= w_fwd_b;
      r_pc4       <= e.pc4e;
      r_rd        <= e.rde;
    end
  end
  assign e.pcSrce    = !rst && !w_stall && (e.jmpe || (e.branche && w_cond));
  assign e.pcTargete = e.jalre ? {w_jalr_sum[XLEN-1:1], 1'b0} : e.pce + e.immexte;
  assign e.stalle    = w_stall;
  assign e.regWrtm   = r_reg_wrt;
  assign e.memWrtm   = r_mem_wrt;
  assign e.resltSrcm = r_reslt_src;
  assign e.aluRsltm  = r_alu_rslt;
  assign e.wrtDatam  = r_wrt_data;
  assign e.pc4m      = r_pc4;
  assign e.rdm       = r_rd;
endmodule

// File: tb/tb_exec_stage.sv
// tb_exec_stage: directed vector and sequence checks for exec_stage
module tb_exec_stage;
  logic clk, rst;
  int   n_chk, n_err;
  exec_stage_if bus();
  exec_stage #(.XLEN(32), .MD_CYCLES(32)) dut (.clk(clk), .rst(rst), .e(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] ctl; logic src; logic [1:0] uj; logic [1:0] fa; logic [1:0] fb;
    logic [31:0] a; logic [31:0] b; logic [31:0] imm; logic [31:0] pc; logic [31:0] rw; logic [31:0] exp;
  } vec_t;
  typedef struct { logic [2:0] f3; logic [31:0] a; logic [31:0] b; logic exp; } br_t;
  vec_t vecs[19];
  br_t  brs[9];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic clear();
    bus.regWrte = 0; bus.memWrte = 0; bus.jmpe = 0; bus.branche = 0; bus.aluSrce = 0; bus.jalre = 0;
    bus.resltSrce = 0; bus.ujMuxe = 0; bus.aluCtrle = 0; bus.funct3e = 0;
    bus.rd1e = 0; bus.rd2e = 0; bus.pce = 0; bus.pc4e = 0; bus.immexte = 0; bus.rde = 0;
    bus.fwdAe = 0; bus.fwdBe = 0; bus.resltw = 0;
  endtask
  task automatic md_run(input string nm, input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int n, bub;
    clear();
    bus.aluCtrle = ctl; bus.rd1e = a; bus.rd2e = b; bus.regWrte = 1; bus.rde = 5;
    #1 chk({nm, " stall start"}, 32'(bus.stalle), 1);
    n = 0; bub = 0;
    while (bus.stalle === 1'b1 && n < 100) begin
      n++;
      @(posedge clk); #1;
      if (n == 1) begin bus.fwdAe = 1; bus.fwdBe = 1; bus.resltw = 32'hBAD; end
      if (bus.regWrtm !== 0 || bus.rdm !== 0 || bus.aluRsltm !== 0) bub++;
    end
    chk({nm, " stall cycles"}, n, 33);
    chk({nm, " bubbles"}, bub, 0);
    @(posedge clk); #1;
    chk({nm, " result"}, bus.aluRsltm, exp);
    chk({nm, " rdm"}, 32'(bus.rdm), 5);
    clear();
  endtask
  initial begin
    n_chk = 0; n_err = 0;
    vecs[0]  = '{4'h0, 1, 0, 0, 0, 32'd5, 32'd0, 32'd7, 0, 0, 32'd12};
    vecs[1]  = '{4'h1, 0, 0, 0, 0, 32'd3, 32'd5, 0, 0, 0, 32'hFFFFFFFE};
    vecs[2]  = '{4'h2, 0, 0, 0, 0, 32'hF0F0, 32'hFF00, 0, 0, 0, 32'hF000};
    vecs[3]  = '{4'h3, 0, 0, 0, 0, 32'hF0F0, 32'hFF00, 0, 0, 0, 32'hFFF0};
    vecs[4]  = '{4'h4, 0, 0, 0, 0, 32'hF0F0, 32'hFF00, 0, 0, 0, 32'h0FF0};
    vecs[5]  = '{4'h5, 0, 0, 0, 0, 32'hFFFFFFFF, 32'd1, 0, 0, 0, 32'd1};
    vecs[6]  = '{4'h6, 0, 0, 0, 0, 32'hFFFFFFFF, 32'd1, 0, 0, 0, 32'd0};
    vecs[7]  = '{4'h7, 0, 0, 0, 0, 32'd1, 32'h21, 0, 0, 0, 32'd2};
    vecs[8]  = '{4'h8, 0, 0, 0, 0, 32'h80000000, 32'd4, 0, 0, 0, 32'h08000000};
    vecs[9]  = '{4'h9, 0, 0, 0, 0, 32'h80000000, 32'd4, 0, 0, 0, 32'hF8000000};
    vecs[10] = '{4'hA, 1, 0, 0, 0, 32'h999, 32'd0, 32'h1234, 0, 0, 32'h1234};
    vecs[11] = '{4'hB, 0, 0, 0, 0, 32'd5, 32'd7, 0, 0, 0, 32'd0};
    vecs[12] = '{4'hD, 0, 0, 0, 0, 32'd5, 32'd7, 0, 0, 0, 32'd0};
    vecs[13] = '{4'h0, 1, 1, 0, 0, 32'h999, 0, 32'd4, 32'h100, 0, 32'h104};
    vecs[14] = '{4'h0, 1, 2, 0, 0, 32'h999, 0, 32'h55, 32'h100, 0, 32'h55};
    vecs[15] = '{4'h0, 1, 3, 0, 0, 32'h10, 0, 32'd1, 32'h100, 0, 32'h11};
    vecs[16] = '{4'h1, 0, 0, 1, 0, 32'h999, 32'd3, 0, 0, 32'h20, 32'h1D};
    vecs[17] = '{4'h1, 0, 0, 3, 0, 32'd7, 32'd2, 0, 0, 32'h20, 32'd5};
    vecs[18] = '{4'h0, 0, 0, 0, 1, 32'd1, 32'h777, 0, 0, 32'd9, 32'd10};
    brs[0] = '{3'b000, 32'h55, 32'h55, 1};
    brs[1] = '{3'b001, 32'h55, 32'h55, 0};
    brs[2] = '{3'b100, 32'hFFFFFFFF, 32'd1, 1};
    brs[3] = '{3'b101, 32'hFFFFFFFF, 32'd1, 0};
    brs[4] = '{3'b110, 32'hFFFFFFFF, 32'd1, 0};
    brs[5] = '{3'b111, 32'hFFFFFFFF, 32'd1, 1};
    brs[6] = '{3'b010, 32'h55, 32'h55, 0};
    brs[7] = '{3'b011, 32'd1, 32'd2, 0};
    brs[8] = '{3'b000, 32'd1, 32'd2, 0};
    clear();
    rst = 1;
    bus.regWrte = 1; bus.jmpe = 1; bus.aluCtrle = 4'b1100; bus.rd1e = 5; bus.rde = 7; bus.pc4e = 32'h44;
    repeat (2) @(posedge clk);
    #1;
    chk("reset stalle", 32'(bus.stalle), 0);
    chk("reset pcSrce", 32'(bus.pcSrce), 0);
    chk("reset M outputs", {bus.aluRsltm ^ bus.wrtDatam ^ bus.pc4m, 3'b0, bus.regWrtm, bus.memWrtm, bus.resltSrcm, bus.rdm} == '0 &&
        (bus.aluRsltm | bus.wrtDatam | bus.pc4m) == 0 ? 1 : 0, 1);
    rst = 0;
    clear();
    bus.aluSrce = 1; bus.rd1e = 5; bus.rd2e = 32'h77; bus.immexte = 7; bus.pc4e = 32'h44;
    bus.memWrte = 1; bus.resltSrce = 2; bus.regWrte = 1; bus.rde = 9;
    #1 chk("add stalle", 32'(bus.stalle), 0);
    @(posedge clk); #1;
    chk("add result", bus.aluRsltm, 12);
    chk("add regWrtm", 32'(bus.regWrtm), 1);
    chk("add memWrtm", 32'(bus.memWrtm), 1);
    chk("add resltSrcm", 32'(bus.resltSrcm), 2);
    chk("add pc4m", bus.pc4m, 32'h44);
    chk("add wrtDatam", bus.wrtDatam, 32'h77);
    chk("add rdm", 32'(bus.rdm), 9);
    for (int i = 0; i < 19; i++) begin
      clear();
      bus.aluCtrle = vecs[i].ctl; bus.aluSrce = vecs[i].src; bus.ujMuxe = vecs[i].uj;
      bus.fwdAe = vecs[i].fa; bus.fwdBe = vecs[i].fb; bus.rd1e = vecs[i].a; bus.rd2e = vecs[i].b;
      bus.immexte = vecs[i].imm; bus.pce = vecs[i].pc; bus.resltw = vecs[i].rw;
      bus.regWrte = 1; bus.rde = 5'(i);
      #1 chk($sformatf("vec%0d stalle", i), 32'(bus.stalle), 0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d alu", i), bus.aluRsltm, vecs[i].exp);
      chk($sformatf("vec%0d rdm", i), 32'(bus.rdm), i);
    end
    clear();
    bus.aluSrce = 1; bus.rd1e = 32'h10;
    @(posedge clk); #1;
    chk("fwd seed", bus.aluRsltm, 32'h10);
    clear();
    bus.aluCtrle = 4'h1; bus.fwdAe = 2; bus.rd1e = 32'h999; bus.rd2e = 3;
    @(posedge clk); #1;
    chk("fwd aluRsltm sub", bus.aluRsltm, 32'h0D);
    bus.fwdAe = 1; bus.resltw = 32'h20;
    @(posedge clk); #1;
    chk("fwd resltw sub", bus.aluRsltm, 32'h1D);
    bus.fwdBe = 2; bus.rd2e = 32'h999;
    @(posedge clk); #1;
    chk("fwdB aluRsltm sub", bus.aluRsltm, 32'h3);
    chk("fwdB wrtDatam", bus.wrtDatam, 32'h1D);
    clear();
    for (int i = 0; i < 9; i++) begin
      bus.branche = 1; bus.pce = 32'h100; bus.immexte = 32'h20;
      bus.funct3e = brs[i].f3; bus.rd1e = brs[i].a; bus.rd2e = brs[i].b;
      #1;
      chk($sformatf("br%0d pcSrce", i), 32'(bus.pcSrce), 32'(brs[i].exp));
      chk($sformatf("br%0d target", i), bus.pcTargete, 32'h120);
    end
    clear();
    bus.jmpe = 1; bus.jalre = 1; bus.rd1e = 32'h203; bus.pce = 32'h500;
    #1;
    chk("jalr pcSrce", 32'(bus.pcSrce), 1);
    chk("jalr target", bus.pcTargete, 32'h202);
    bus.fwdAe = 1; bus.resltw = 32'h301; bus.immexte = 32'h10;
    #1 chk("jalr fwd target", bus.pcTargete, 32'h310);
    clear();
    @(posedge clk); #1;
    md_run("mul", 4'b1100, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD);
    md_run("divu", 4'b1110, 32'd100, 32'd7, 32'd14);
    md_run("remu", 4'b1111, 32'd100, 32'd7, 32'd2);
    md_run("divu0", 4'b1110, 32'hDEAD, 32'd0, 32'hFFFFFFFF);
    md_run("remu0", 4'b1111, 32'd9, 32'd0, 32'd9);
    clear();
    bus.aluCtrle = 4'b1100; bus.rd1e = 32'h1234; bus.rd2e = 32'h10; bus.regWrte = 1; bus.rde = 6; bus.jmpe = 1;
    #1 chk("abort pcSrce masked", 32'(bus.pcSrce), 0);
    repeat (11) @(posedge clk);
    #1 chk("abort busy stalle", 32'(bus.stalle), 1);
    rst = 1;
    #1 chk("abort rst stalle", 32'(bus.stalle), 0);
    @(posedge clk); #1;
    rst = 0;
    chk("abort M alu", bus.aluRsltm, 0);
    chk("abort M ctrl", {27'b0, bus.regWrtm, bus.memWrtm, bus.resltSrcm, 1'b0} | 32'(bus.rdm), 0);
    clear();
    bus.aluSrce = 1; bus.rd1e = 5; bus.immexte = 7; bus.regWrte = 1; bus.rde = 3;
    #1 chk("post-abort stalle", 32'(bus.stalle), 0);
    @(posedge clk); #1;
    chk("post-abort add", bus.aluRsltm, 12);
    chk("post-abort regWrtm", 32'(bus.regWrtm), 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/exec_stage.md
Name: exec_stage

Overview:
- Execute stage of the in-order 5-stage RISC-V core. Sits between the decode/execute pipeline register and the memory stage.
- Consumes the E-stage control and data outputs, then performs operand forwarding, the ALU operation and branch/jump resolution.
- Runs an iterative 32-cycle unsigned multiply/divide unit that stalls the front end while busy.
- Contains the execute/memory pipeline register.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
MD_CYCLES, 32, iteration count of the multiply/divide unit.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
regWrte, memWrte, jmpe, branche, aluSrce, jalre  in  1 each  E-stage control
resltSrce, ujMuxe  in  2 each  result-select / ALU srcA select (00 rs1, 01 pc, 10 zero)
aluCtrle  in  4  operation code
funct3e  in  3  branch condition
rd1e, rd2e, pce, pc4e, immexte  in  32 each  E-stage data
rde  in  5  destination register
fwdAe, fwdBe  in  2 each  forward select (00 reg, 01 resltw, 10 aluRsltm)
resltw  in  32  writeback result used for forwarding
pcSrce  out  1  redirect fetch
pcTargete  out  32  redirect address
stalle  out  1  E busy; hazard unit holds F/D/E
regWrtm, memWrtm  out  1 each  M-stage control
resltSrcm  out  2  M-stage result select
aluRsltm, wrtDatam, pc4m  out  32 each  M-stage data
rdm  out  5  M-stage destination

Behaviour:
- Reset: every M-stage output is 0; the FSM is IDLE and the counter is 0. pcSrce and stalle are 0 while rst is high. rst mid-operation aborts the mul/div with no result.
- Forwarding (combinational): srcA_fwd = mux(fwdAe) over rd1e/resltw/aluRsltm; fwdBe does the same for rd2e. Select value 11 is treated as 00. wrtData = srcB_fwd.
- srcA = ujMuxe select (rs1 fwd, pce, 0); value 11 is treated as 00. srcB = aluSrce ? immexte : srcB_fwd.
- ALU codes, combinational:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor.
  - 0101 slt (signed), 0110 sltu.
  - 0111 sll, 1000 srl, 1001 sra, each using shamt = srcB[4:0].
  - 1010 pass srcB.
  - 1011 is reserved and gives 0.
  - 1100 mul (low 32), 1110 divu, 1111 remu.
  - 1101 is reserved and gives 0 with no stall.
- Branch: funct3e selects 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu, compared on forwarded rs1/rs2. Values 010/011 never take the branch.
- pcSrce = jmpe | (branche & cond); it is forced to 0 while stalle=1.
- Targets: pcTargete = jalre ? ((srcA_fwd + immexte) & ~1) : (pce + immexte).
- Multiply/divide FSM, states IDLE, BUSY, DONE:
  - IDLE with an M op (1100/1110/1111): stalle=1 combinationally in the same cycle. Operands are latched, the counter is cleared, next state is BUSY.
  - BUSY: one shift-add (mul) or restoring-subtract (div) step per cycle with stalle=1. After MD_CYCLES steps, next state is DONE.
  - DONE: stalle=0. The result drives the ALU output, the EX/MEM register captures it at the clock edge, next state is IDLE.
  - Total residency in E is MD_CYCLES+2 cycles. Forwarding inputs are ignored after operand latch.
  - Divide by zero: divu gives 0xFFFFFFFF and remu gives the dividend, with the same latency.
  - mul keeps the low 32 bits; overflow is discarded.
- EX/MEM register: while stalle=1 it loads a bubble (regWrtm=0, memWrtm=0, resltSrcm=0, data 0, rdm=0). Otherwise it loads the E values on every clock. Single-cycle ops have latency 1 cycle to M.

Test Plan:
1. add with rd1e=5, immexte=7, aluSrce=1 -> next cycle aluRsltm=12, regWrtm=1, stalle never high.
2. Forwarding: fwdAe=10, aluRsltm=0x10 held, rd2e=3, sub -> aluRsltm=0x0D. Then fwdAe=01 with resltw=0x20 -> 0x1D.
3. beq with both operands equal, pce=0x100, immexte=0x20 -> pcSrce=1, pcTargete=0x120. jalr with rs1=0x203, imm=0 -> pcTargete=0x202.
4. mul 0xFFFFFFFF*3 -> stalle high for exactly 33 cycles, bubbles in M during the stall, then aluRsltm=0xFFFFFFFD.
5. divu 100/7 -> 14; remu -> 2. divu x/0 -> 0xFFFFFFFF; remu 9/0 -> 9.
6. rst asserted at BUSY cycle 10 -> next cycle all M outputs are 0, stalle=0. A following add completes in 1 cycle.
